// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32x32 multiply / 32/32 divide unit
module muldiv_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  output logic        busy
);

  // req_op[1] selects divide, req_op[0] selects signed operands
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] d_q, d_d;          // multiplicand (mult) or divisor (div) magnitude
  logic [31:0] hi_q, hi_d;        // partial product high / partial remainder
  logic [31:0] lo_q, lo_d;        // multiplier shifting out / quotient shifting in
  logic [5:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_hi_q, resp_hi_d;
  logic [31:0] resp_lo_q, resp_lo_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod_neg;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_hi    = resp_hi_q;
  assign resp_lo    = resp_lo_q;

  // Datapath helpers: operand magnitudes and one shift-add / restoring step
  always_comb begin
    a_neg     = req_op[0] & req_a[31];
    b_neg     = req_op[0] & req_b[31];
    a_mag     = a_neg ? (32'd0 - req_a) : req_a;
    b_mag     = b_neg ? (32'd0 - req_b) : req_b;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : 33'd0);
    div_shift = {hi_q, lo_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, d_q};
    prod_neg  = 64'd0 - {hi_q, lo_q};
  end

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    d_d          = d_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_hi_d    = resp_hi_q;
    resp_lo_d    = resp_lo_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          cnt_d    = 6'd0;
          hi_d     = 32'd0;
          if (req_op[1]) begin
            d_d  = b_mag;
            lo_d = a_mag;
          end else begin
            d_d  = a_mag;
            lo_d = b_mag;
          end
          state_d = CALC;
        end
      end
      CALC: begin
        if (op_q[1]) begin
          // A divisor of zero never borrows, so the quotient fills with ones
          // and the remainder ends up as the dividend: no special case needed.
          if (!div_diff[33]) begin
            hi_d = div_diff[31:0];
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = div_shift[31:0];
            lo_d = {lo_q[30:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[32:1];
          lo_d = {mul_sum[0], lo_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          if (sign_a_q ^ sign_b_q) lo_d = 32'd0 - lo_q;
          if (sign_a_q)            hi_d = 32'd0 - hi_q;
        end else if (sign_a_q ^ sign_b_q) begin
          hi_d = prod_neg[63:32];
          lo_d = prod_neg[31:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_hi_d    = hi_q;
          resp_lo_d    = lo_q;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      op_q         <= 2'd0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      d_q          <= 32'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      cnt_q        <= 6'd0;
      resp_valid_q <= 1'b0;
      resp_hi_q    <= 32'd0;
      resp_lo_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      d_q          <= d_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_hi_q    <= resp_hi_d;
      resp_lo_q    <= resp_lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_MULT  = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

  muldiv_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hi    (resp_hi),
    .resp_lo    (resp_lo),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accepting edge until resp_valid; checks the latency
  task automatic wait_resp(input string tag);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (resp_valid) begin
        cyc = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(cyc), 64'd34);
  endtask

  task automatic wait_ready(input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    check({tag, "_ready_wait"}, 64'(ok), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    wait_ready(tag);
    resp_ready = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h0BAD_F00D;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_resp(tag);
    check({tag, "_hi"}, 64'(resp_hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(resp_lo), 64'(exp_lo));
    tick();
    check({tag, "_ready_after"}, 64'(req_ready), 64'd1);
    check({tag, "_valid_after"}, 64'(resp_valid), 64'd0);
    check({tag, "_held"}, {resp_hi, resp_lo}, {exp_hi, exp_lo});
  endtask

  logic [31:0] held_hi, held_lo;

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    tick();
    tick();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out", {resp_hi, resp_lo}, 64'd0);
    resetn = 1'b1;
    check("rst_req_ready", 64'(req_ready), 64'd1);

    run_op("multu_150x50", OP_MULTU, 32'd150, 32'd50, 32'd0, 32'd7500);
    run_op("mult_m1x2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    run_op("div_m10_3", OP_DIV, 32'hFFFF_FFF6, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_10_0", OP_DIVU, 32'd10, 32'd0, 32'd10, 32'hFFFF_FFFF);
    run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    // Back-pressure: response held while a new request waits
    wait_ready("stall");
    resp_ready = 1'b0;
    req_op     = OP_DIVU;
    req_a      = 32'd100;
    req_b      = 32'd7;
    req_valid  = 1'b1;
    tick();
    req_op = OP_MULTU;
    req_a  = 32'd3;
    req_b  = 32'd5;
    wait_resp("stall");
    held_hi = resp_hi;
    held_lo = resp_lo;
    check("stall_first", {held_hi, held_lo}, {32'd2, 32'd14});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", 64'(resp_valid), 64'd1);
      check("stall_no_accept", 64'(req_ready), 64'd0);
      check("stall_data", {resp_hi, resp_lo}, {held_hi, held_lo});
    end
    resp_ready = 1'b1;
    tick();
    check("stall_hs_ready", 64'(req_ready), 64'd1);
    check("stall_hs_valid", 64'(resp_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    check("stall_second_busy", 64'(busy), 64'd1);
    wait_resp("stall_second");
    check("stall_second_res", {resp_hi, resp_lo}, {32'd0, 32'd15});
    tick();

    // Reset mid-CALC discards the operation
    wait_ready("rst_mid");
    req_op    = OP_MULTU;
    req_a     = 32'd150;
    req_b     = 32'd50;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    #1;
    check("rst_mid_valid", 64'(resp_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_out", {resp_hi, resp_lo}, 64'd0);
    tick();
    resetn    = 1'b1;
    req_op    = OP_MULTU;
    req_a     = 32'd3;
    req_b     = 32'd4;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    check("rst_mid_accept", 64'(busy), 64'd1);
    wait_resp("rst_mid_3x4");
    check("rst_mid_3x4", {resp_hi, resp_lo}, {32'd0, 32'd12});
    tick();
    check("rst_mid_final_ready", 64'(req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
